// File: rtl/l1_dcache_wb_pkg.sv
// l1_dcache_wb_pkg: FSM state encodings and address-field widths for the L1 data cache.
package l1_dcache_wb_pkg;
  localparam logic [1:0] IDLE = 2'd0, WRITEBACK = 2'd1, REFILL = 2'd2;
  localparam int OFFSET_W = 2;
  function automatic int word_w(input int line_words);
    return $clog2(line_words);
  endfunction
  function automatic int index_w(input int num_sets);
    return $clog2(num_sets);
  endfunction
  function automatic int tag_w(input int addr_w, input int num_sets, input int line_words);
    return addr_w - OFFSET_W - word_w(line_words) - index_w(num_sets);
  endfunction
endpackage

// File: rtl/dcache_tag_store.sv
// dcache_tag_store: per-line valid/dirty/tag storage with combinational lookup.
module dcache_tag_store
  import l1_dcache_wb_pkg::*;
#(
  parameter int NUM_SETS = 16,
  parameter int TAG_W = 24
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [index_w(NUM_SETS)-1:0] index,
  input  logic [TAG_W-1:0]            tag,
  input  logic                        fill,
  input  logic                        mark_dirty,
  output logic                        hit,
  output logic                        line_valid,
  output logic                        line_dirty,
  output logic [TAG_W-1:0]            line_tag
);
  logic [NUM_SETS-1:0] valid, dirty;
  logic [TAG_W-1:0] tags [NUM_SETS];
  assign line_valid = valid[index];
  assign line_dirty = dirty[index];
  assign line_tag = tags[index];
  assign hit = valid[index] && tags[index] == tag;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill) begin
      valid[index] <= 1'b1;
      dirty[index] <= 1'b0;
    end else if (mark_dirty) dirty[index] <= 1'b1;
  end
  always_ff @(posedge clock) if (fill) tags[index] <= tag;
endmodule

// File: rtl/l1_dcache_wb.sv
// l1_dcache_wb: blocking direct-mapped write-back, write-allocate L1 data cache
// with a word-serial req/ack refill/write-back port.
module l1_dcache_wb
  import l1_dcache_wb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int NUM_SETS = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_be,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);
  localparam int WORD_W = word_w(LINE_WORDS);
  localparam int INDEX_W = index_w(NUM_SETS);
  localparam int TAG_W = tag_w(ADDR_W, NUM_SETS, LINE_WORDS);
  logic [1:0] state;
  logic [WORD_W-1:0] cnt, word;
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0] tag, line_tag;
  logic hit, line_valid, line_dirty, idle, req, hit_now, miss_now, fill, unused_ok;
  logic [31:0] data [NUM_SETS][LINE_WORDS];
  assign word = cpu_addr[OFFSET_W +: WORD_W];
  assign index = cpu_addr[OFFSET_W + WORD_W +: INDEX_W];
  assign tag = cpu_addr[ADDR_W-1 -: TAG_W];
  assign unused_ok = ^cpu_addr[OFFSET_W-1:0];
  assign idle = state == IDLE;
  assign req = cpu_read | cpu_write;
  assign hit_now = idle && req && hit;
  assign miss_now = idle && req && !hit;
  assign fill = state == REFILL && mem_ack && &cnt;
  dcache_tag_store #(.NUM_SETS(NUM_SETS), .TAG_W(TAG_W)) u_tags (
    .clock(clock), .reset(reset), .index(index), .tag(tag), .fill(fill),
    .mark_dirty(hit_now && cpu_write), .hit(hit), .line_valid(line_valid),
    .line_dirty(line_dirty), .line_tag(line_tag)
  );
  // Stall is gated by reset so an abandoned miss releases the pipeline immediately.
  assign cpu_stall = reset && (!idle || (req && !hit));
  assign cpu_rdata = (hit_now && cpu_read) ? data[index][word] : '0;
  assign mem_req = !idle;
  assign mem_we = state == WRITEBACK;
  assign mem_addr = state == WRITEBACK ? {line_tag, index, cnt, 2'b00} :
                    state == REFILL ? {tag, index, cnt, 2'b00} : '0;
  assign mem_wdata = state == WRITEBACK ? data[index][cnt] : '0;
  always_ff @(posedge clock) begin
    if (state == REFILL && mem_ack) data[index][cnt] <= mem_rdata;
    else if (hit_now && cpu_write)
      for (int b = 0; b < 4; b++) if (cpu_be[b]) data[index][word][8*b +: 8] <= cpu_wdata[8*b +: 8];
  end
  // The burst counter wraps to zero on the last word, ready for the next phase.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      if (hit_now) hit_count <= hit_count + 32'd1;
      if (miss_now) begin
        miss_count <= miss_count + 32'd1;
        cnt <= '0;
        state <= (line_valid && line_dirty) ? WRITEBACK : REFILL;
      end
      if (!idle && mem_ack) begin
        cnt <= cnt + 1'b1;
        if (&cnt) state <= state == WRITEBACK ? REFILL : IDLE;
      end
    end
  end
endmodule

// File: tb/tb_l1_dcache_wb.sv
// tb_l1_dcache_wb: directed plus random accesses checked against a transparent-memory
// reference and an abstract line-occupancy model, with a delayed-ack memory responder.
module tb_l1_dcache_wb;
  logic clock = 1'b0, reset = 1'b0;
  logic cpu_read = 1'b0, cpu_write = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, mem_rdata = '0;
  logic [3:0] cpu_be = '0;
  logic [31:0] cpu_rdata, mem_addr, mem_wdata, hit_count, miss_count;
  logic cpu_stall, mem_req, mem_we, mem_ack = 1'b0;
  int checks = 0, errors = 0, exp_hit = 0, exp_miss = 0, ack_delay = 0, rd_acks = 0, wait_cnt = 0;
  logic [31:0] bmem [int unsigned];
  logic [31:0] golden [int unsigned];
  logic [31:0] wlog[$], rlog[$];
  logic [31:0] hold_addr = '0;
  bit mv[16], md[16];
  int unsigned mt[16];

  l1_dcache_wb dut (
    .clock(clock), .reset(reset), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0000_1234;
  endfunction
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : init_val(a);
  endfunction
  function automatic logic [31:0] gold(input logic [31:0] a);
    return golden.exists(a) ? golden[a] : init_val(a);
  endfunction

  // Backing memory: acks each word ack_delay cycles after it is first requested.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      mem_ack = 1'b0;
      if (reset && mem_req) begin
        if (wait_cnt == 0) hold_addr = mem_addr;
        if (wait_cnt >= ack_delay) begin
          chk("addr_hold", mem_addr, hold_addr);
          if (mem_we) begin
            chk("wb_data", mem_wdata, gold(mem_addr));
            bmem[mem_addr] = mem_wdata;
            wlog.push_back(mem_addr);
          end else begin
            mem_rdata = mem_val(mem_addr);
            rlog.push_back(mem_addr);
            rd_acks++;
          end
          mem_ack = 1'b1;
          wait_cnt = 0;
        end else wait_cnt++;
      end else wait_cnt = 0;
    end
  end

  task automatic access(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input int dly);
    int unsigned s, t, n, words;
    bit hit, ev;
    logic [31:0] ov, nv, base, obase, wa;
    @(negedge clock);
    ack_delay = dly;
    wlog.delete();
    rlog.delete();
    cpu_read = !w;
    cpu_write = w;
    cpu_addr = a;
    cpu_wdata = d;
    cpu_be = be;
    s = (a >> 4) % 16;
    t = a >> 8;
    wa = a & ~32'h3;
    base = a & ~32'hF;
    hit = mv[s] && mt[s] == t;
    #1;
    chk("stall_now", cpu_stall, hit ? 0 : 1);
    if (hit) chk("hit_no_req", mem_req, 0);
    else begin
      ev = mv[s] && md[s];
      obase = (mt[s] << 8) | (s << 4);
      exp_miss++;
      n = 0;
      while (cpu_stall === 1'b1 && n < 2000) begin
        @(negedge clock);
        #1;
        n++;
      end
      chk("miss_timeout", n < 2000, 1);
      words = ev ? 8 : 4;
      chk("stall_cycles", n, 1 + words * (dly + 1));
      chk("wb_words", wlog.size(), ev ? 4 : 0);
      chk("rf_words", rlog.size(), 4);
      foreach (wlog[i]) chk("wb_addr", wlog[i], obase + 32'(4 * i));
      foreach (rlog[i]) chk("rf_addr", rlog[i], base + 32'(4 * i));
      mv[s] = 1'b1;
      md[s] = 1'b0;
      mt[s] = t;
    end
    if (w) begin
      ov = gold(wa);
      for (int b = 0; b < 4; b++) nv[8*b +: 8] = be[b] ? d[8*b +: 8] : ov[8*b +: 8];
      golden[wa] = nv;
      md[s] = 1'b1;
    end else chk("rdata", cpu_rdata, gold(wa));
    exp_hit++;
    @(posedge clock);
    #1;
    chk("hit_count", hit_count, exp_hit);
    chk("miss_count", miss_count, exp_miss);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] a;
    for (int i = 0; i < 4; i++) begin
      bmem[32'h100 + 4 * i] = 32'hA0 + i;
      golden[32'h100 + 4 * i] = 32'hA0 + i;
    end
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_hits", hit_count, 0);
    chk("rst_misses", miss_count, 0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    access(1'b0, 32'h100, '0, '0, 0);
    chk("cold_rdata", cpu_rdata, 32'hA0);
    access(1'b0, 32'h104, '0, '0, 0);
    access(1'b1, 32'h108, 32'hDEADBEEF, 4'b0011, 0);
    access(1'b0, 32'h108, '0, '0, 0);
    chk("partial_rdata", golden[32'h108], 32'h0000BEEF);
    access(1'b0, 32'h200, '0, '0, 0);
    chk("evicted_word", bmem[32'h108], 32'h0000BEEF);
    access(1'b0, 32'h310, '0, '0, 5);
    access(1'b1, 32'h20C, 32'h12345678, 4'b0000, 0);
    @(negedge clock);
    wlog.delete();
    rlog.delete();
    ack_delay = 0;
    rd_acks = 0;
    cpu_read = 1'b1;
    cpu_write = 1'b0;
    cpu_addr = 32'h300;
    n = 0;
    while (rd_acks < 2 && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("rst_reach", n < 200, 1);
    @(posedge clock);
    #3 reset = 1'b0;
    #1;
    chk("midrst_mem_req", mem_req, 0);
    chk("midrst_stall", cpu_stall, 0);
    chk("midrst_hits", hit_count, 0);
    chk("midrst_misses", miss_count, 0);
    cpu_read = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
    end
    golden = bmem;
    exp_hit = 0;
    exp_miss = 0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    access(1'b0, 32'h104, '0, '0, 0);
    chk("post_rst_rdata", cpu_rdata, 32'hA1);
    for (int k = 0; k < 150; k++) begin
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4) |
          (32'($urandom_range(0, 3)) << 2);
      access(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), $urandom_range(0, 2));
    end
    @(negedge clock);
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    repeat (3) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/l1_dcache_wb.md
Name: l1_dcache_wb

Overview:
- Parametrised, blocking, direct-mapped, write-back, write-allocate L1 data cache.
- Sits between the pipeline MEM stage and the backing data memory, in place of the single-cycle data memory.
- Hits complete in the request cycle with no stall.
- Misses assert stall to the pipeline while the cache bursts a line out (if dirty) and a line in, over a word-serial req/ack memory interface.

Parameters:
ADDR_W, 32, byte-address width
NUM_SETS, 16, number of lines; power of two, >=2
LINE_WORDS, 4, 32-bit words per line; power of two, >=2

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
cpu_read  in  1  load request from EXMEM stage
cpu_write  in  1  store request from EXMEM stage
cpu_addr  in  ADDR_W  byte address; bits [1:0] ignored
cpu_wdata  in  32  store data, already lane-aligned
cpu_be  in  4  byte enables for store
cpu_rdata  out  32  load data, valid when read and stall low
cpu_stall  out  1  freeze pipeline; request must be held stable
mem_req  out  1  memory word transfer request
mem_we  out  1  1 = write word, 0 = read word
mem_addr  out  ADDR_W  word-aligned memory address
mem_wdata  out  32  write-back word
mem_rdata  in  32  refill word, valid with mem_ack
mem_ack  in  1  one-cycle completion of current word
hit_count  out  32  wrapping count of hit accesses
miss_count  out  32  wrapping count of miss accesses

Behaviour:
- Address split:
  - offset = addr[1:0]
  - word = next log2(LINE_WORDS) bits
  - index = next log2(NUM_SETS) bits
  - tag = remaining upper bits
- Storage: per-line valid, dirty, tag; data array of NUM_SETS x LINE_WORDS words. Data array is not reset.
- Reset (async, low):
  - state IDLE; all valid and dirty cleared; word counter 0; counters 0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_stall=0, cpu_rdata=0.
  - An in-flight memory burst is abandoned.
- States: IDLE, WRITEBACK, REFILL.
- IDLE, no request: stall 0, no action.
- IDLE hit (valid and tag match):
  - cpu_stall=0 combinationally.
  - Read: cpu_rdata = addressed word, same cycle.
  - Write: enabled bytes merged at the clock edge; dirty set.
  - hit_count+1 at the edge.
- IDLE miss:
  - cpu_stall=1 combinationally; miss_count+1 at the edge.
  - Next state is WRITEBACK if the line is valid and dirty, else REFILL; word counter cleared.
- WRITEBACK:
  - mem_req=1, mem_we=1, mem_addr={old tag, index, counter, 2'b00}, mem_wdata = line word[counter].
  - On mem_ack: counter+1. On the last ack: counter=0, go to REFILL.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr={cpu tag, index, counter, 2'b00}.
  - On mem_ack: mem_rdata written into word[counter].
  - On the last ack: tag written, valid=1, dirty=0, go to IDLE.
- Request replay: on return to IDLE the held request is re-evaluated as a hit. It counts once in hit_count and the store merges then, so a miss counts only in miss_count.
- cpu_stall is 1 in every cycle of WRITEBACK and REFILL, including the final-ack cycle.
- No mem_ack: state and counter hold indefinitely; mem_req stays high.
- mem_ack outside WRITEBACK/REFILL is ignored.
- cpu_read and cpu_write both high: treated as write; cpu_rdata undefined.
- cpu_be=0 on a write hit: data unchanged, dirty still set.
- Counters wrap from 0xFFFFFFFF to 0.
- Outputs mem_addr/mem_wdata: combinational from state/counter; don't-care when mem_req=0 (RTL drives 0).

Decomposition:
- Shared package/header: state encodings (IDLE, WRITEBACK, REFILL) and derived widths OFFSET_W, INDEX_W, TAG_W as constant functions of the parameters.
- One natural sub-module, dcache_tag_store: valid/dirty/tag arrays with combinational lookup and hit output, synchronous update ports, async clear on reset.
- Data array and FSM stay in the top.

Test Plan:
1. Cold miss, default params: after reset, read 0x100; memory returns 0xA0,0xA1,0xA2,0xA3 each 1 cycle after req.
   -> 4 read reqs at 0x100,0x104,0x108,0x10C, no writes.
   -> stall high through the last ack, then cpu_rdata=0xA0, stall 0.
   -> miss_count=1, hit_count=1.
2. Read hit: read 0x104 next -> no mem_req, cpu_rdata=0xA1 same cycle, stall 0, hit_count=2.
3. Partial store: write 0x108, data 0xDEADBEEF, be=4'b0011 -> no stall; then read 0x108 -> cpu_rdata=0x0000BEEF.
4. Dirty eviction: read 0x200 (index 0, tag 2).
   -> 4 write reqs to 0x100..0x10C, data 0xA0,0xA1,0x0000BEEF,0xA3.
   -> then 4 read reqs 0x200..0x20C; data from 0x200 returned.
   -> miss_count=2.
5. Slow memory: mem_ack delayed 5 cycles per word -> mem_addr and counter hold for each word; stall held; 20+ stall cycles; correct data returned.
6. Reset mid-refill: assert reset after the second refill ack.
   -> mem_req=0 and stall=0 immediately (async), counters 0.
   -> after release, read 0x104 misses and performs a full refill from 0x100.
